// File: rtl/tcm_pkg.sv
// Shared TCM definitions: access-size encodings, controller state encoding and
// the alignment check shared by the data and instruction TCM paths.
package tcm_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // True when the access cannot be served: misaligned half/word or illegal size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    access_err = 1'b0;
            SZ_H:    access_err = off[0];
            SZ_W:    access_err = |off;
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dtcm_rdata_ext.sv
// Load data alignment: selects the addressed lane of an SRAM word and
// sign- or zero-extends it to the full data width.
module dtcm_rdata_ext
    import tcm_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] dout,
    input  logic [1:0]    off,
    input  logic [1:0]    size,
    input  logic          uns,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0]        lane;
    logic signed [DW-1:0] byte_sext;
    logic signed [DW-1:0] half_sext;

    assign lane      = dout >> {off, 3'b000};
    assign byte_sext = DW'($signed(lane[7:0]));
    assign half_sext = DW'($signed(lane[15:0]));

    always_comb begin
        rdata = lane;
        case (size)
            SZ_B:    rdata = uns ? {{(DW-8){1'b0}}, lane[7:0]}   : byte_sext;
            SZ_H:    rdata = uns ? {{(DW-16){1'b0}}, lane[15:0]} : half_sext;
            default: rdata = lane;
        endcase
    end

endmodule

// File: rtl/dtcm_ctrl.sv
// Data TCM request controller: one load/store at a time, drives the single-port
// SRAM and returns an aligned load result, a store acknowledge or an error.
module dtcm_ctrl
    import tcm_pkg::*;
#(
    parameter int DW     = 32,
    parameter int MW     = DW / 8,
    parameter int AW     = 32,
    parameter int RAM_AW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic              ram_we,
    output logic [MW-1:0]     ram_wem,
    input  logic [DW-1:0]     ram_dout
);

    function automatic logic [MW-1:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    store_mask = MW'(1) << off;
            SZ_H:    store_mask = MW'(3) << off;
            default: store_mask = '1;
        endcase
    endfunction

    function automatic logic [DW-1:0] store_data(input logic [1:0] size, input logic [DW-1:0] wdata);
        case (size)
            SZ_B:    store_data = {(DW/8){wdata[7:0]}};
            SZ_H:    store_data = {(DW/16){wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                req_err;
    logic [RAM_AW-1:0]   addr_q;
    logic [1:0]          off_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [DW-1:0]       rdata_q;
    logic                err_q;
    logic [DW-1:0]       ext_rdata;
    logic                unused_addr;

    // Address bits above the TCM window are ignored.
    assign unused_addr = ^req_addr[AW-1:RAM_AW+2];

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = access_err(req_size, req_addr[1:0]);
    assign rsp_valid = (state == ST_RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    dtcm_rdata_ext #(
        .DW(DW)
    ) u_rdata_ext (
        .dout  (ram_dout),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .rdata (ext_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wem   = '0;
        ram_din   = store_data(req_size, req_wdata);
        case (state)
            ST_IDLE: begin
                ram_addr = req_addr[RAM_AW+1:2];
                if (accept) begin
                    if (req_err) begin
                        state_nxt = ST_RSP;
                    end else if (req_wen) begin
                        ram_we    = 1'b1;
                        ram_wem   = store_mask(req_size, req_addr[1:0]);
                        state_nxt = ST_RSP;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD:   state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture on accept; load result captured one cycle later in RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr[RAM_AW+1:2];
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            rdata_q <= '0;
            err_q   <= req_err;
        end else if (state == ST_RD) begin
            rdata_q <= ext_rdata;
        end
    end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed bench for dtcm_ctrl with a behavioural single-port SRAM on the ram_* ports.
module tb_dtcm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [3:0]  ram_wem;
    logic [31:0] ram_dout;

    logic [31:0] mem [512];
    int          we_count = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dtcm_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_wem      (ram_wem),
        .ram_dout     (ram_dout)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            we_count <= we_count + 1;
            for (int i = 0; i < 4; i++)
                if (ram_wem[i]) mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request through to response; hold keeps rsp_ready low for that many cycles.
    task automatic txn(input string tag, input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_we, input logic [3:0] exp_wem, input logic [31:0] exp_din,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input int hold);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " ram_addr"}, 32'(ram_addr), 32'(addr[10:2]));
        check({tag, " ram_we"}, 32'(ram_we), 32'(exp_we));
        check({tag, " ram_wem"}, 32'(ram_wem), 32'(exp_wem));
        if (exp_we) check({tag, " ram_din"}, ram_din, exp_din);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = 32'h5555_AAAA; req_wen = ~wen;
        check({tag, " we_pulse"}, 32'(ram_we), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        held = rsp_rdata;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata, held);
            check({tag, " hold ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " idle valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " idle ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int we_before;
        for (int i = 0; i < 512; i++) mem[i] = '0;

        // Reset: a store presented during reset must not reach the SRAM.
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst ram_we", 32'(ram_we), 32'd0);
        check("rst ram_wem", 32'(ram_wem), 32'd0);
        check("rst rdata", rsp_rdata, 32'd0);
        check("rst err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        check("rst we_count", 32'(we_count), 32'd0);

        txn("SW10", 1, 2'b10, 0, 32'h10, 32'h8765_4321, 1, 4'hF, 32'h8765_4321, 0, 32'h0, 0, 0);
        txn("LW10", 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 1, 32'h8765_4321, 0, 0);
        txn("LB13", 0, 2'b00, 0, 32'h13, 32'h0, 0, 4'h0, 32'h0, 1, 32'hFFFF_FF87, 0, 0);
        txn("LBU13", 0, 2'b00, 1, 32'h13, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0000_0087, 0, 0);
        txn("LB10", 0, 2'b00, 0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0000_0021, 0, 0);
        txn("SH12", 1, 2'b01, 0, 32'h12, 32'h1234_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0, 0, 0);
        txn("LW10b", 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 1, 32'hBEEF_4321, 0, 0);
        txn("LH12", 0, 2'b01, 0, 32'h12, 32'h0, 0, 4'h0, 32'h0, 1, 32'hFFFF_BEEF, 0, 0);
        txn("LHU12", 0, 2'b01, 1, 32'h12, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0000_BEEF, 0, 0);

        we_before = we_count;
        txn("ERR LW11", 0, 2'b10, 0, 32'h11, 32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0);
        txn("ERR SH13", 1, 2'b01, 0, 32'h13, 32'hCAFE_F00D, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0);
        txn("ERR SZ11", 1, 2'b11, 0, 32'h10, 32'hCAFE_F00D, 0, 4'h0, 32'h0, 0, 32'h0, 1, 0);
        check("ERR no writes", 32'(we_count), 32'(we_before));
        txn("LW10 after err", 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 1, 32'hBEEF_4321, 0, 0);

        txn("SB11", 1, 2'b00, 0, 32'h11, 32'h0000_015A, 1, 4'b0010, 32'h5A5A_5A5A, 0, 32'h0, 0, 0);
        txn("LW10c", 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 1, 32'hBEEF_5A21, 0, 0);
        txn("SW7FC", 1, 2'b10, 0, 32'h7FC, 32'hA5A5_0F0F, 1, 4'hF, 32'hA5A5_0F0F, 0, 32'h0, 0, 0);
        txn("LW hiaddr", 0, 2'b10, 0, 32'h1000_07FC, 32'h0, 0, 4'h0, 32'h0, 1, 32'hA5A5_0F0F, 0, 0);
        txn("LHU7FE", 0, 2'b01, 1, 32'h7FE, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0000_A5A5, 0, 0);

        // Backpressure: response holds for 5 cycles with rsp_ready low.
        txn("BP LW10", 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 1, 32'hBEEF_5A21, 0, 5);

        // Reset while a load sits in RD.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("MIDRST rsp_valid", 32'(rsp_valid), 32'd0);
        check("MIDRST req_ready", 32'(req_ready), 32'd0);
        check("MIDRST ram_we", 32'(ram_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("MIDRST hold valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("MIDRST ready after", 32'(req_ready), 32'd1);
        txn("LW after rst", 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 1, 32'hBEEF_5A21, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dtcm_ctrl.md
# dtcm_ctrl

Request-side controller for the data TCM. Accepts one load/store request at a time from the core's memory stage over a valid/ready handshake. Drives the single-port TCM SRAM (word address, lane-replicated write data, byte write mask, write enable), then returns a response: aligned and sign/zero-extended load data, or a write acknowledge. Misaligned or illegal-size requests are rejected with an error response and never touch the SRAM.

## Interface
- DW, 32: data width; fixed 32 in this revision.
- MW, 4: byte-mask width (DW/8).
- AW, 32: request byte-address width.
- RAM_AW, 9: SRAM word-address width (depth 2^RAM_AW = 512).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_addr  in  AW  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (LBU/LHU).
- req_wdata  in  DW  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DW  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal size.
- ram_addr  out  RAM_AW  word address = req_addr[RAM_AW+1:2].
- ram_din  out  DW  lane-replicated write data.
- ram_we  out  1  SRAM write enable.
- ram_wem  out  MW  SRAM byte write mask.
- ram_dout  in  DW  SRAM read data, valid the cycle after a read address is presented with ram_we=0.

## Operation
- States: IDLE, RD (waiting for SRAM data), RSP (holding response).
- req_ready = (state==IDLE) and not rst.
- Accept = req_valid & req_ready. In IDLE, ram_addr tracks req_addr combinationally. In all other states ram_addr holds the registered address of the accepted request.
- Alignment: byte is always legal. Half requires addr[0]=0. Word requires addr[1:0]=0. Size 11 is always an error.
- Accepted error -> RSP with rsp_err=1 and rsp_rdata=0. ram_we=0 and ram_wem=0.
- Accepted legal store:
  - ram_we=1 in the accept cycle.
  - Byte: ram_wem = 1<<addr[1:0], ram_din = {4{wdata[7:0]}}.
  - Half: ram_wem = 3<<addr[1:0], ram_din = {2{wdata[15:0]}}.
  - Word: ram_wem = 4'hF, ram_din = wdata.
  - Next state RSP, rsp_rdata=0, rsp_err=0.
- Accepted legal load: ram_we=0, ram_wem=0. Register addr[1:0], size and unsigned; next state RD.
- RD: select lane (ram_dout >> 8*offset), truncate to 8/16/32 bits, then sign- or zero-extend. Register the result into rsp_rdata; next state RSP.
- RSP: rsp_valid=1, outputs stable until rsp_ready. On rsp_ready, go to IDLE. A new request cannot be accepted in the same cycle.
- ram_we and ram_wem are 0 in every cycle except a store-accept cycle.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, registered address 0. ram_we and ram_wem are 0 while rst is high.
- Load latency: accept at cycle N, rsp_valid at N+2.
- Store and error latency: accept at N, rsp_valid at N+1.
- Back-to-back throughput: best case one load per 3 cycles, one store per 2.
- rsp_ready held low: response holds indefinitely. ram_we stays 0, so SRAM contents are unchanged.
- Reset asserted in RD or RSP: the pending response is dropped and rsp_valid falls immediately (async). A store already written in its accept cycle stays written.
- req_* may change freely when req_ready=0; it is sampled only on accept.

## Structure
- Shared package tcm_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - the state encoding;
  - a function for the misalignment check, reused later by the ITCM fetch path.
- One sub-module, dtcm_rdata_ext: a combinational lane-select plus sign/zero-extend, instantiated in the RD path.
- The SRAM itself is outside this block. The bench connects it directly to the ram_* ports.

## Test plan
- Word store then load: SW 0x8765_4321 at 0x10 -> ram_addr=4, ram_wem=F, ram_we=1 for one cycle, rsp at N+1. LW 0x10 -> rsp_rdata=0x8765_4321 at N+2.
- Byte lanes: with word 4 = 0x8765_4321, LB 0x13 -> 0xFFFF_FF87. LBU 0x13 -> 0x0000_0087. LB 0x10 -> 0x0000_0021.
- Half store: SH 0xBEEF at 0x12 -> ram_wem=4'b1100, ram_din=0xBEEF_BEEF. A following LW 0x10 -> 0xBEEF_4321. LH 0x12 -> 0xFFFF_BEEF.
- Errors: LW 0x11, SH 0x13 and size 11 each -> rsp_err=1 and rsp_rdata=0, with ram_we never asserted. The word at 0x10 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load. Then:
  - rsp_valid and rsp_rdata stay stable;
  - req_ready stays 0;
  - on release, IDLE is reached next cycle.
- Reset mid-op: assert rst in RD -> rsp_valid=0 and req_ready=0 during reset. After release, a fresh LW returns correct data.
